// File: rtl/sonar_array_driver.sv
// rtl/sonar_array_driver.sv - HC-SR04 sonar array sequencer: trigger, echo timing, distance in mm
// Sweeps enabled sensors lowest-first, one at a time, reporting one result per sensor.
module sonar_array_driver #(
   parameter int FREQ       = 50_000_000,
   parameter int CHANNELS   = 4,
   parameter int DIST_W     = 16,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int GAP_US     = 60000,
   localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                continuous,
   input  logic [CHANNELS-1:0] ch_mask,
   input  logic [CHANNELS-1:0] echo,
   output logic [CHANNELS-1:0] trig,
   output logic                busy,
   output logic                valid,
   output logic [CW-1:0]       ch_id,
   output logic [DIST_W-1:0]   distance,
   output logic                timeout
);

   localparam int          DIV      = FREQ / 1_000_000;
   localparam int          PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [31:0] MM_Q16   = 32'd11239;
   localparam logic [31:0] DIST_MAX = 32'((64'd1 << DIST_W) - 64'd1);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      REPORT,
      HOLDOFF
   } state_t;

   state_t              state_q, state_d;
   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [CW-1:0]       ch_q, ch_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [31:0]         acc_q, acc_d;
   logic [CHANNELS-1:0] echo_s1_q, echo_s2_q;
   logic [CHANNELS-1:0] trig_q, trig_d;
   logic                valid_q, valid_d;
   logic [CW-1:0]       ch_id_q, ch_id_d;
   logic [DIST_W-1:0]   dist_q, dist_d;
   logic                to_q, to_d;

   logic                tick;
   logic                echo_ch;
   logic [CW-1:0]       low_idx;
   logic [CW-1:0]       nxt_idx;
   logic                nxt_found;
   logic                to_rep;
   logic [31:0]         acc_hi;
   logic [31:0]         dist_sat;

   assign tick    = (pre_q == PW'(DIV - 1));
   assign echo_ch = echo_s2_q[ch_q];

   // Lowest enabled sensor of a fresh mask, and next enabled sensor above the current one.
   always_comb begin
      low_idx   = '0;
      nxt_idx   = '0;
      nxt_found = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            low_idx = CW'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            nxt_idx   = CW'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      valid_d  = 1'b0;
      ch_id_d  = ch_id_q;
      dist_d   = dist_q;
      to_d     = to_q;
      to_rep   = 1'b0;
      acc_hi   = '0;
      dist_sat = '0;
      trig_d   = '0;
      pre_d    = '0;

      case (state_q)
         IDLE: begin
            if (start && (ch_mask != '0)) begin
               mask_d  = ch_mask;
               ch_d    = low_idx;
               state_d = TRIG;
            end
         end
         TRIG: begin
            if (tick) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q == 32'(TRIG_US - 1)) begin
                  state_d = WAIT_ECHO;
               end
            end
         end
         WAIT_ECHO: begin
            if (echo_ch) begin
               state_d = MEASURE;
            end else if (tick) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q == 32'(TIMEOUT_US - 1)) begin
                  state_d = REPORT;
                  to_rep  = 1'b1;
               end
            end
         end
         MEASURE: begin
            // The tick landing on the cycle that sees echo low still belongs to the pulse:
            // the synchronizer delays the fall by the same amount as the rise.
            if (tick) begin
               cnt_d = cnt_q + 32'd1;
               acc_d = acc_q + MM_Q16;
            end
            if (!echo_ch) begin
               state_d = REPORT;
            end else if (tick && (cnt_q == 32'(TIMEOUT_US - 1))) begin
               state_d = REPORT;
               to_rep  = 1'b1;
            end
         end
         REPORT: begin
            state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (tick) begin
               cnt_d = cnt_q + 32'd1;
               if (cnt_q == 32'(GAP_US - 1)) begin
                  if (nxt_found) begin
                     ch_d    = nxt_idx;
                     state_d = TRIG;
                  end else if (continuous && (ch_mask != '0)) begin
                     mask_d  = ch_mask;
                     ch_d    = low_idx;
                     state_d = TRIG;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == REPORT) begin
         acc_hi   = {16'd0, acc_d[31:16]};
         dist_sat = (acc_hi > DIST_MAX) ? DIST_MAX : acc_hi;
         valid_d  = 1'b1;
         ch_id_d  = ch_q;
         to_d     = to_rep;
         dist_d   = to_rep ? '1 : dist_sat[DIST_W-1:0];
      end

      // Every state entry restarts the microsecond timebase and the shared counters.
      if (state_d != state_q) begin
         cnt_d = '0;
         acc_d = '0;
         pre_d = '0;
      end else if (!tick) begin
         pre_d = pre_q + 1'b1;
      end

      if (state_d == TRIG) begin
         trig_d[ch_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         ch_q      <= '0;
         pre_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         echo_s1_q <= '0;
         echo_s2_q <= '0;
         trig_q    <= '0;
         valid_q   <= 1'b0;
         ch_id_q   <= '0;
         dist_q    <= '0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         ch_q      <= ch_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         echo_s1_q <= echo;
         echo_s2_q <= echo_s1_q;
         trig_q    <= trig_d;
         valid_q   <= valid_d;
         ch_id_q   <= ch_id_d;
         dist_q    <= dist_d;
         to_q      <= to_d;
      end
   end

   assign trig     = trig_q;
   assign busy     = (state_q != IDLE);
   assign valid    = valid_q;
   assign ch_id    = ch_id_q;
   assign distance = dist_q;
   assign timeout  = to_q;

endmodule

// File: tb/tb_sonar_array_driver.sv
// tb/tb_sonar_array_driver.sv - directed self-checking bench for sonar_array_driver
// Three instances: 1 MHz timebase (fast sweeps), 50 MHz (real trigger width), 1 MHz with DIST_W=8.
module tb_sonar_array_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int P_A_TRIG_ON = 0, P_A_TRIG_OFF = 1, P_A_VALID = 2, P_A_IDLE = 3,
                  P_A_Q4 = 4, P_A_TRIG0 = 5, P_B_TRIG_ON = 6, P_B_TRIG_OFF = 7,
                  P_B_VALID = 8, P_B_IDLE = 9, P_C_TRIG_ON = 10, P_C_TRIG_OFF = 11,
                  P_C_VALID = 12, P_C_IDLE = 13;

   logic        a_rst, a_start, a_cont, a_busy, a_valid, a_to;
   logic [3:0]  a_mask, a_echo, a_echo_r, a_echo_f, a_trig;
   logic [1:0]  a_ch;
   logic [15:0] a_dist;

   logic        b_rst, b_start, b_cont, b_busy, b_valid, b_to;
   logic [3:0]  b_mask, b_echo, b_trig;
   logic [1:0]  b_ch;
   logic [15:0] b_dist;

   logic        c_rst, c_start, c_cont, c_busy, c_valid, c_to;
   logic [0:0]  c_mask, c_echo, c_trig, c_ch;
   logic [7:0]  c_dist;

   assign a_echo = a_echo_r | a_echo_f;

   sonar_array_driver #(.FREQ(1_000_000), .CHANNELS(4), .DIST_W(16), .TRIG_US(10),
                        .TIMEOUT_US(6000), .GAP_US(100)) u_a (
      .clk(clk), .rst(a_rst), .start(a_start), .continuous(a_cont), .ch_mask(a_mask),
      .echo(a_echo), .trig(a_trig), .busy(a_busy), .valid(a_valid), .ch_id(a_ch),
      .distance(a_dist), .timeout(a_to));

   sonar_array_driver #(.FREQ(50_000_000), .CHANNELS(4), .DIST_W(16), .TRIG_US(10),
                        .TIMEOUT_US(20), .GAP_US(5)) u_b (
      .clk(clk), .rst(b_rst), .start(b_start), .continuous(b_cont), .ch_mask(b_mask),
      .echo(b_echo), .trig(b_trig), .busy(b_busy), .valid(b_valid), .ch_id(b_ch),
      .distance(b_dist), .timeout(b_to));

   sonar_array_driver #(.FREQ(1_000_000), .CHANNELS(1), .DIST_W(8), .TRIG_US(10),
                        .TIMEOUT_US(3000), .GAP_US(10)) u_c (
      .clk(clk), .rst(c_rst), .start(c_start), .continuous(c_cont), .ch_mask(c_mask),
      .echo(c_echo), .trig(c_trig), .busy(c_busy), .valid(c_valid), .ch_id(c_ch),
      .distance(c_dist), .timeout(c_to));

   int a_q_ch[$], a_q_dist[$], a_q_to[$];
   int a_multi = 0;

   always @(negedge clk) begin
      if (a_valid) begin
         a_q_ch.push_back(int'(a_ch));
         a_q_dist.push_back(int'(a_dist));
         a_q_to.push_back(int'(a_to));
      end
      if ($countones(a_trig) > 1) a_multi++;
   end

   // Sensor model for instance A: echo of a_echo_len cycles, 20 cycles after the trigger ends.
   logic a_resp_en = 1'b0;
   int   a_echo_len = 0;
   int   rch = 0;
   initial begin
      a_echo_r = '0;
      forever begin
         @(negedge clk);
         if (a_resp_en && (a_trig != '0)) begin
            for (int i = 0; i < 4; i++) if (a_trig[i]) rch = i;
            for (int k = 0; k < 2000 && a_trig != '0; k++) @(negedge clk);
            repeat (20) @(negedge clk);
            a_echo_r[rch] = 1'b1;
            repeat (a_echo_len) @(negedge clk);
            a_echo_r[rch] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         P_A_TRIG_ON:  return a_trig != '0;
         P_A_TRIG_OFF: return a_trig == '0;
         P_A_VALID:    return a_valid;
         P_A_IDLE:     return !a_busy;
         P_A_Q4:       return a_q_ch.size() >= 4;
         P_A_TRIG0:    return a_trig[0];
         P_B_TRIG_ON:  return b_trig != '0;
         P_B_TRIG_OFF: return b_trig == '0;
         P_B_VALID:    return b_valid;
         P_B_IDLE:     return !b_busy;
         P_C_TRIG_ON:  return c_trig != '0;
         P_C_TRIG_OFF: return c_trig == '0;
         P_C_VALID:    return c_valid;
         P_C_IDLE:     return !c_busy;
         default:      return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, input string tag, output int waited);
      int k = 0;
      while (!probe(sel) && k < budget) begin
         @(negedge clk);
         k++;
      end
      waited = k;
      check({tag, "_reached"}, 32'(probe(sel)), 32'd1);
   endtask

   task automatic clear_a();
      a_q_ch.delete();
      a_q_dist.delete();
      a_q_to.delete();
      a_multi = 0;
   endtask

   int w;

   initial begin
      a_rst = 1'b1; a_start = 1'b0; a_cont = 1'b0; a_mask = '0; a_echo_f = '0;
      b_rst = 1'b1; b_start = 1'b0; b_cont = 1'b0; b_mask = '0; b_echo = '0;
      c_rst = 1'b1; c_start = 1'b0; c_cont = 1'b0; c_mask = '0; c_echo = '0;
      repeat (3) @(negedge clk);
      check("rst_trig", a_trig, 0);
      check("rst_busy", a_busy, 0);
      check("rst_valid", a_valid, 0);
      check("rst_ch_id", a_ch, 0);
      check("rst_distance", a_dist, 0);
      check("rst_timeout", a_to, 0);
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

      // Single channel, 1000 us echo
      clear_a();
      a_mask = 4'b0100; a_echo_len = 1000; a_resp_en = 1'b1;
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
      wait_for(P_A_TRIG_ON, 50, "a1_trig_on", w);
      check("a1_trig_sel", a_trig, 4'b0100);
      wait_for(P_A_TRIG_OFF, 100, "a1_trig_off", w);
      check("a1_trig_width", w, 10);
      wait_for(P_A_VALID, 2000, "a1_valid", w);
      check("a1_ch_id", a_ch, 2);
      check("a1_distance", a_dist, 171);
      check("a1_timeout", a_to, 0);
      wait_for(P_A_IDLE, 500, "a1_idle", w);
      check("a1_busy_fall", w, 101);
      check("a1_results", a_q_ch.size(), 1);

      // Three channels in order, mask change mid-sweep ignored
      clear_a();
      a_mask = 4'b1011; a_echo_len = 5831;
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
      a_mask = 4'b0000;
      wait_for(P_A_IDLE, 25000, "a2_idle", w);
      check("a2_results", a_q_ch.size(), 3);
      for (int i = 0; i < 3 && i < a_q_ch.size(); i++) begin
         check($sformatf("a2_ch_id%0d", i), a_q_ch[i], (i == 2) ? 3 : i);
         check($sformatf("a2_distance%0d", i), a_q_dist[i], 999);
         check($sformatf("a2_timeout%0d", i), a_q_to[i], 0);
      end
      check("a2_one_trig", a_multi, 0);

      // No echo: timeout 6000 us after trigger falls
      clear_a();
      a_resp_en = 1'b0; a_mask = 4'b0001;
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
      wait_for(P_A_TRIG_ON, 50, "a3_trig_on", w);
      wait_for(P_A_TRIG_OFF, 100, "a3_trig_off", w);
      wait_for(P_A_VALID, 7000, "a3_valid", w);
      check("a3_latency_in_window", 32'(w >= 5997 && w <= 6003), 1);
      check("a3_timeout", a_to, 1);
      check("a3_distance", a_dist, 16'hFFFF);
      wait_for(P_A_IDLE, 500, "a3_idle", w);

      // Stuck-high echo: stale rise, then measurement timeout
      a_echo_f = 4'b0001;
      repeat (3) @(negedge clk);
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
      wait_for(P_A_VALID, 8000, "a4_valid", w);
      check("a4_timeout", a_to, 1);
      check("a4_distance", a_dist, 16'hFFFF);
      a_echo_f = 4'b0000;
      wait_for(P_A_IDLE, 500, "a4_idle", w);

      // Continuous 0,1,0,1,... then stop after the sweep in progress
      clear_a();
      a_resp_en = 1'b1; a_echo_len = 50; a_cont = 1'b1; a_mask = 4'b0011;
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
      wait_for(P_A_Q4, 2000, "a5_four", w);
      wait_for(P_A_TRIG0, 400, "a5_ch0_again", w);
      a_cont = 1'b0;
      wait_for(P_A_IDLE, 2000, "a5_idle", w);
      check("a5_results", a_q_ch.size(), 6);
      for (int i = 0; i < 6 && i < a_q_ch.size(); i++) begin
         check($sformatf("a5_ch_id%0d", i), a_q_ch[i], i % 2);
         check($sformatf("a5_distance%0d", i), a_q_dist[i], 8);
      end
      a_resp_en = 1'b0;

      // 50 MHz: 500-cycle trigger and 12 us echo
      b_mask = 4'b0100;
      b_start = 1'b1; @(negedge clk); b_start = 1'b0;
      wait_for(P_B_TRIG_ON, 50, "b1_trig_on", w);
      check("b1_trig_sel", b_trig, 4'b0100);
      wait_for(P_B_TRIG_OFF, 1000, "b1_trig_off", w);
      check("b1_trig_width", w, 500);
      repeat (100) @(negedge clk);
      b_echo = 4'b0100;
      repeat (600) @(negedge clk);
      b_echo = 4'b0000;
      wait_for(P_B_VALID, 100, "b1_valid", w);
      check("b1_ch_id", b_ch, 2);
      check("b1_distance", b_dist, 2);
      check("b1_timeout", b_to, 0);
      wait_for(P_B_IDLE, 500, "b1_idle", w);

      b_mask = 4'b0001;
      b_start = 1'b1; @(negedge clk); b_start = 1'b0;
      wait_for(P_B_TRIG_ON, 50, "b2_trig_on", w);
      wait_for(P_B_TRIG_OFF, 1000, "b2_trig_off", w);
      wait_for(P_B_VALID, 1200, "b2_valid", w);
      check("b2_latency_in_window", 32'(w >= 997 && w <= 1003), 1);
      check("b2_timeout", b_to, 1);
      wait_for(P_B_IDLE, 500, "b2_idle", w);

      // Reset at cycle 200 of the trigger pulse
      b_start = 1'b1; @(negedge clk); b_start = 1'b0;
      wait_for(P_B_TRIG_ON, 50, "b3_trig_on", w);
      repeat (199) @(negedge clk);
      check("b3_trig_mid", b_trig, 4'b0001);
      b_rst = 1'b1;
      @(negedge clk);
      check("b3_rst_trig", b_trig, 0);
      check("b3_rst_busy", b_busy, 0);
      check("b3_rst_distance", b_dist, 0);
      check("b3_rst_timeout", b_to, 0);
      b_rst = 1'b0; b_mask = 4'b0000; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      repeat (3) @(negedge clk);
      check("b3_zero_mask_ignored", b_busy, 0);
      b_rst = 1'b1; @(negedge clk);
      b_rst = 1'b0; b_mask = 4'b0010; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b3_first_cycle_busy", b_busy, 1);
      check("b3_first_cycle_trig", b_trig, 4'b0010);
      b_rst = 1'b1;

      // DIST_W=8: 2000 us saturates, 1000 us fits
      c_mask = 1'b1;
      for (int t = 0; t < 2; t++) begin
         c_start = 1'b1; @(negedge clk); c_start = 1'b0;
         wait_for(P_C_TRIG_ON, 50, "c_trig_on", w);
         wait_for(P_C_TRIG_OFF, 100, "c_trig_off", w);
         repeat (10) @(negedge clk);
         c_echo = 1'b1;
         repeat ((t == 0) ? 2000 : 1000) @(negedge clk);
         c_echo = 1'b0;
         wait_for(P_C_VALID, 100, "c_valid", w);
         check($sformatf("c%0d_distance", t), c_dist, (t == 0) ? 255 : 171);
         check($sformatf("c%0d_timeout", t), c_to, 0);
         check($sformatf("c%0d_ch_id", t), c_ch, 0);
         wait_for(P_C_IDLE, 100, "c_idle", w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
